hilo_div_ctrl: RTL

- Sequencer and HI/LO result holder between the control unit and the iterative divider.
- Accepts a divide request from the control unit, launches the divider, and waits for it with a watchdog.
- Captures the divider's remainder into HI and quotient into LO, and reports divide-by-zero or timeout.
- Provides HI/LO to mfhi/mflo, supports mthi/mtlo writes, and drives the pipeline stall while a divide is in flight.

---
 rtl/hilo_pkg.sv | 19 +
 rtl/hilo_regs.sv | 50 +++++
 rtl/hilo_div_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO divide sequencer: FSM states, default
// sizing and the exception cause reported on a divide by zero.
package hilo_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_TIMEOUT = 40;

  // Cause code handed to the exception unit alongside div_zero_exc.
  localparam logic [4:0] EXC_DIV_ZERO = 5'd15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    ZERO    = 3'd4
  } hilo_state_e;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO register pair. Divider capture and mthi/mtlo writes never overlap
// in time (capture only in WAIT, writes only in IDLE); capture is given
// priority anyway so the register contents stay well defined.
module hilo_regs
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_en_i,
  input  logic [WIDTH-1:0] cap_hi_i,
  input  logic [WIDTH-1:0] cap_lo_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Select the next HI/LO value from capture, move-to writes or hold.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mthi_i) hi_d = wdata_i;
    if (mtlo_i) lo_d = wdata_i;
    if (cap_en_i) begin
      hi_d = cap_hi_i;
      lo_d = cap_lo_i;
    end
  end

  // HI/LO storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/hilo_div_ctrl.sv
// Divide sequencer: accepts a request, launches the iterative divider,
// waits under a watchdog, captures remainder/quotient into HI/LO and
// flags divide-by-zero or timeout. busy doubles as the pipeline stall.
module hilo_div_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_done,
  input  logic             div_zero,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero_exc,
  output logic             timeout_err
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  hilo_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic             timeout_q, timeout_d;
  logic             accept;
  logic             wait_capture;
  logic             wait_expire;
  logic             in_idle;

  // WAIT exit priority: divider zero flag, then result, then watchdog.
  assign in_idle      = (state_q == IDLE);
  assign accept       = in_idle && start;
  assign wait_capture = (state_q == WAIT) && !div_zero && div_done;
  assign wait_expire  = (state_q == WAIT) && !div_zero && !div_done && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (srcB == '0) ? ZERO : LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT: begin
        if (div_zero)         state_d = ZERO;
        else if (div_done)    state_d = CAPTURE;
        else if (wait_expire) state_d = IDLE;
      end
      CAPTURE: state_d = IDLE;
      ZERO:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded pulses and the stall.
  always_comb begin
    busy         = !in_idle;
    div_start    = (state_q == LAUNCH);
    done         = (state_q == CAPTURE);
    div_zero_exc = (state_q == ZERO);
  end

  // Operand latch, watchdog counter and sticky timeout next-state.
  always_comb begin
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q || wait_expire;
    if (accept) begin
      div_a_d = srcA;
      div_b_d = srcB;
    end
    if (state_q == LAUNCH)    cnt_d = '0;
    else if (state_q == WAIT) cnt_d = cnt_q + CNT_W'(1);
  end

  // Operand, counter and error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_a_q   <= '0;
      div_b_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign timeout_err = timeout_q;

  hilo_regs #(
    .WIDTH(WIDTH)
  ) u_regs (
    .clk     (clk),
    .rst_n   (reset),
    .cap_en_i(wait_capture),
    .cap_hi_i(div_hi),
    .cap_lo_i(div_lo),
    .mthi_i  (mthi && in_idle),
    .mtlo_i  (mtlo && in_idle),
    .wdata_i (wdata),
    .hi_o    (hi),
    .lo_o    (lo)
  );

endmodule
